// File: rtl/mult_sequencer.sv
// Multi-cycle signed multiply controller: stalls the pipeline while a radix-2
// shift-add loop runs on latched operand magnitudes, then writes HI/LO.
module mult_sequencer #(
    parameter int unsigned WIDTH    = 32,
    parameter logic [3:0]  MULT_SEL = 4'b1011
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned    CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_count;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH:0]       r_acc;
    logic                 r_neg;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;

    logic                 w_start;
    logic                 w_last;
    logic [WIDTH:0]       w_addend;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_acc_nxt;
    logic [WIDTH-1:0]     w_mplier_nxt;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_result;

    // Unsigned magnitude; the most negative value maps onto itself, which is
    // exactly 2^(WIDTH-1) when read as unsigned.
    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v);
        mag_w = v[WIDTH-1] ? -v : v;
    endfunction

    assign w_start = valid & (alu_sel == MULT_SEL) & ~flush
                   & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_last  = (r_state == S_RUN) & (r_count == CNT_LAST);

    assign w_addend     = r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}};
    assign w_sum        = r_acc + w_addend;
    assign w_acc_nxt    = {1'b0, w_sum[WIDTH:1]};
    assign w_mplier_nxt = {w_sum[0], r_mplier[WIDTH-1:1]};
    // Full product as it will sit in {acc,mplier} after this step's shift.
    assign w_prod       = {w_sum, r_mplier[WIDTH-1:1]};
    assign w_result     = r_neg ? -w_prod : w_prod;

    assign busy = (r_state == S_RUN) | w_start;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = w_start ? S_RUN : S_IDLE;
                S_RUN:   w_state_nxt = (r_count == CNT_LAST) ? S_DONE : S_RUN;
                S_DONE:  w_state_nxt = w_start ? S_RUN : S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Operand latch, shift-add datapath and HI/LO result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= {CW{1'b0}};
            r_mcand  <= {WIDTH{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_acc    <= {(WIDTH+1){1'b0}};
            r_neg    <= 1'b0;
            r_hi     <= {WIDTH{1'b0}};
            r_lo     <= {WIDTH{1'b0}};
            r_done   <= 1'b0;
        end else begin
            r_done <= w_last & ~flush;
            if (w_start) begin
                r_mcand  <= mag_w(src_a);
                r_mplier <= mag_w(src_b);
                r_neg    <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
                r_acc    <= {(WIDTH+1){1'b0}};
                r_count  <= {CW{1'b0}};
            end else if ((r_state == S_RUN) && !flush) begin
                r_acc    <= w_acc_nxt;
                r_mplier <= w_mplier_nxt;
                r_count  <= r_count + CNT_ONE;
                if (w_last) begin
                    r_hi <= w_result[2*WIDTH-1:WIDTH];
                    r_lo <= w_result[WIDTH-1:0];
                end else begin
                    r_hi <= r_hi;
                    r_lo <= r_lo;
                end
            end else begin
                r_acc    <= r_acc;
                r_mplier <= r_mplier;
                r_count  <= r_count;
            end
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: latency, stall window, signed products,
// flush, async reset mid-run, back-to-back accept and non-mult pass-through.
module tb_mult_sequencer;

    localparam logic [3:0] MULT = 4'b1011;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [3:0]  alu_sel;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    mult_sequencer #(.WIDTH(32), .MULT_SEL(MULT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (valid),
        .alu_sel (alu_sel),
        .src_a   (src_a),
        .src_b   (src_b),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept a mult in the current cycle, then follow it to its done pulse.
    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp_p);
        int busy_cnt;
        int done_cyc;
        valid   = 1'b1;
        alu_sel = MULT;
        src_a   = a;
        src_b   = b;
        #1;
        busy_cnt = busy ? 1 : 0;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            step();
            valid = 1'b0;
            src_a = $urandom;
            src_b = $urandom;
            #1;
            if (busy) busy_cnt++;
            if (done) done_cyc = cyc;
        end
        check_eq({tag, "_done_cycle"}, done_cyc, 33);
        check_eq({tag, "_busy_cycles"}, busy_cnt, 33);
        check_eq({tag, "_product"}, {hi, lo}, exp_p);
        step();
        #1;
        check_eq({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        int done_cnt;
        int done_cyc;
        rst_n   = 1'b0;
        valid   = 1'b0;
        alu_sel = 4'b0000;
        src_a   = 32'd0;
        src_b   = 32'd0;
        flush   = 1'b0;
        #2;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_hilo", {hi, lo}, 64'd0);
        #10 rst_n = 1'b1;
        step();

        // Basic and signed products, including the most negative operand.
        run_mult("m3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
        run_mult("mneg1x2", 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        run_mult("mneg7x6", 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
        run_mult("mmin_sq", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

        // Flush mid-run with a valid mult held in the same cycle.
        valid = 1'b1; alu_sel = MULT; src_a = 32'd9; src_b = 32'd9;
        for (int i = 0; i < 5; i++) begin
            step();
            valid = 1'b0;
        end
        flush = 1'b1; valid = 1'b1; src_a = 32'd1; src_b = 32'd1;
        step();
        flush = 1'b0; valid = 1'b0;
        #1;
        check_eq("flush_busy", busy, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) done_cnt++;
        end
        check_eq("flush_no_done", done_cnt, 0);
        check_eq("flush_hilo_kept", {hi, lo}, 64'h4000_0000_0000_0000);

        // Flush beats a simultaneous start in IDLE.
        flush = 1'b1; valid = 1'b1; alu_sel = MULT;
        #1;
        check_eq("flush_vs_start_busy", busy, 1'b0);
        step();
        flush = 1'b0; valid = 1'b0;
        #1;
        check_eq("flush_vs_start_idle", busy, 1'b0);

        // Async reset in the middle of a run.
        valid = 1'b1; alu_sel = MULT; src_a = 32'h1234; src_b = 32'h5678;
        for (int i = 0; i < 10; i++) begin
            step();
            valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_hilo", {hi, lo}, 64'd0);
        #1 rst_n = 1'b1;
        step();
        run_mult("m7x6", 32'd7, 32'd6, 64'd42);

        // Back-to-back: second mult presented in the DONE cycle.
        valid = 1'b1; alu_sel = MULT; src_a = 32'd100; src_b = 32'd200;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            step();
            valid = 1'b0;
            #1;
            if (done) done_cyc = cyc;
        end
        check_eq("b2b_first_done", done_cyc, 33);
        check_eq("b2b_first_prod", {hi, lo}, 64'd20000);
        valid = 1'b1; src_a = 32'hFFFF_FFFD; src_b = 32'd5;
        #1;
        check_eq("b2b_accept_busy", busy, 1'b1);
        done_cyc = -1;
        for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            step();
            valid = 1'b0;
            #1;
            if (done) done_cyc = cyc;
        end
        check_eq("b2b_second_done", done_cyc, 33);
        check_eq("b2b_second_prod", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        step();

        // Non-mult select and invalid mult do nothing.
        valid = 1'b1; alu_sel = 4'b0010; src_a = 32'd4; src_b = 32'd4;
        #1;
        check_eq("add_busy", busy, 1'b0);
        step();
        #1;
        check_eq("add_busy_next", busy, 1'b0);
        valid = 1'b0; alu_sel = MULT;
        #1;
        check_eq("novalid_busy", busy, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 36; i++) begin
            step();
            if (done || busy) done_cnt++;
        end
        check_eq("passthru_idle", done_cnt, 0);
        check_eq("passthru_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
